// File: rtl/ili934x_pkg.sv
// Shared constants and FSM state encoding for the ILI934x rectangle-fill scheduler.
package ili934x_pkg;

    localparam int DEF_X_RES = 240;
    localparam int DEF_Y_RES = 320;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETW   = 3'd1,
        S_START  = 3'd2,
        S_STREAM = 3'd3,
        S_FINISH = 3'd4
    } sched_state_e;

    function automatic logic [15:0] clip16(input logic [15:0] v, input logic [15:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/ili934x_rect_sched_if.sv
// Scheduler-to-panel-driver link: window command, stream start and the pixel stream.
interface ili934x_rect_sched_if;
    logic        win_set_stb;
    logic [15:0] win_x0;
    logic [15:0] win_y0;
    logic [15:0] win_x1;
    logic [15:0] win_y1;
    logic        stream_start;
    // A pixel beat transfers on a rising edge where pix_valid and pix_ready are both high;
    // once raised, pix_valid and pix_data hold until that transfer happens.
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        drv_busy;

    modport master (
        output win_set_stb, win_x0, win_y0, win_x1, win_y1,
        output stream_start, pix_data, pix_valid,
        input  pix_ready, drv_busy
    );

    modport slave (
        input  win_set_stb, win_x0, win_y0, win_x1, win_y1,
        input  stream_start, pix_data, pix_valid,
        output pix_ready, drv_busy
    );
endinterface

// File: rtl/ili934x_rr_arb2.sv
// Two-way round-robin arbiter; requester 0 wins a tie straight out of reset.
module ili934x_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) gnt = 2'b01;
        else if (req[1])                 gnt = 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       last <= 1'b1;
        else if (advance) last <= gnt[1];
    end
endmodule

// File: rtl/ili934x_rect_sched.sv
// Accepts rectangle-fill commands from two requesters and sequences window set,
// memory-write start and the solid-colour pixel stream towards the panel driver.
module ili934x_rect_sched
    import ili934x_pkg::*;
#(
    parameter int X_RES = DEF_X_RES,
    parameter int Y_RES = DEF_Y_RES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_x0,
    input  logic [15:0] req0_y0,
    input  logic [15:0] req0_x1,
    input  logic [15:0] req0_y1,
    input  logic [15:0] req0_color,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_x0,
    input  logic [15:0] req1_y0,
    input  logic [15:0] req1_x1,
    input  logic [15:0] req1_y1,
    input  logic [15:0] req1_color,
    ili934x_rect_sched_if.master drv,
    output logic        busy,
    output logic        grant_id,
    output logic        done_stb,
    output logic        err_stb,
    output logic [2:0]  state_dbg
);
    localparam logic [15:0] X_MAX = 16'(X_RES - 1);
    localparam logic [15:0] Y_MAX = 16'(Y_RES - 1);

    sched_state_e state;
    logic [1:0]   gnt;
    logic         accept, sel, bad;
    logic [15:0]  sx0, sy0, sx1, sy1, scol;
    logic [15:0]  x0_q, y0_q, x1_q, y1_q, color_q;
    logic [16:0]  cnt, w, h;

    ili934x_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .gnt     (gnt)
    );

    // rst_n gates the grant so ready stays low while reset is held, even with valid high.
    assign accept     = rst_n && init_done && (state == S_IDLE) && (gnt != 2'b00);
    assign req0_ready = accept && gnt[0];
    assign req1_ready = accept && gnt[1];
    assign sel        = gnt[1];

    assign sx0  = sel ? req1_x0    : req0_x0;
    assign sy0  = sel ? req1_y0    : req0_y0;
    assign sx1  = sel ? req1_x1    : req0_x1;
    assign sy1  = sel ? req1_y1    : req0_y1;
    assign scol = sel ? req1_color : req0_color;
    assign bad  = (sx0 > sx1) || (sy0 > sy1) || (sx0 > X_MAX) || (sy0 > Y_MAX);

    // Stored corners are already clipped, so x1_q >= x0_q and y1_q >= y0_q.
    assign w = {1'b0, x1_q - x0_q} + 17'd1;
    assign h = {1'b0, y1_q - y0_q} + 17'd1;

    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;
    assign drv.pix_data = color_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            grant_id         <= 1'b0;
            done_stb         <= 1'b0;
            err_stb          <= 1'b0;
            drv.win_set_stb  <= 1'b0;
            drv.stream_start <= 1'b0;
            drv.pix_valid    <= 1'b0;
            drv.win_x0       <= '0;
            drv.win_y0       <= '0;
            drv.win_x1       <= '0;
            drv.win_y1       <= '0;
            x0_q             <= '0;
            y0_q             <= '0;
            x1_q             <= '0;
            y1_q             <= '0;
            color_q          <= '0;
            cnt              <= '0;
        end else begin
            drv.win_set_stb  <= 1'b0;
            drv.stream_start <= 1'b0;
            done_stb         <= 1'b0;
            err_stb          <= 1'b0;
            if (state != S_IDLE && !init_done) begin
                state         <= S_IDLE;
                drv.pix_valid <= 1'b0;
                cnt           <= '0;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        grant_id <= sel;
                        err_stb  <= bad;
                        if (!bad) begin
                            x0_q    <= sx0;
                            y0_q    <= sy0;
                            x1_q    <= clip16(sx1, X_MAX);
                            y1_q    <= clip16(sy1, Y_MAX);
                            color_q <= scol;
                            state   <= S_SETW;
                        end
                    end
                    S_SETW: if (!drv.drv_busy) begin
                        drv.win_set_stb <= 1'b1;
                        drv.win_x0      <= x0_q;
                        drv.win_y0      <= y0_q;
                        drv.win_x1      <= x1_q;
                        drv.win_y1      <= y1_q;
                        state           <= S_START;
                    end
                    S_START: if (!drv.drv_busy) begin
                        drv.stream_start <= 1'b1;
                        drv.pix_valid    <= 1'b1;
                        cnt              <= w * h;
                        state            <= S_STREAM;
                    end
                    S_STREAM: if (drv.pix_valid && drv.pix_ready) begin
                        cnt <= cnt - 17'd1;
                        if (cnt == 17'd1) begin
                            drv.pix_valid <= 1'b0;
                            state         <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        done_stb <= 1'b1;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ili934x_rect_sched.sv
// Self-checking bench for ili934x_rect_sched: vector table, hand sequences and random rectangles.
module tb_ili934x_rect_sched;
    import ili934x_pkg::*;

    localparam int X_RES = 240;
    localparam int Y_RES = 320;

    logic clk, rst_n, init_done;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_x0, req0_y0, req0_x1, req0_y1, req0_color;
    logic [15:0] req1_x0, req1_y0, req1_x1, req1_y1, req1_color;
    logic busy, grant_id, done_stb, err_stb;
    logic [2:0] state_dbg;

    ili934x_rect_sched_if drv ();

    ili934x_rect_sched #(.X_RES(X_RES), .Y_RES(Y_RES)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x0(req0_x0), .req0_y0(req0_y0), .req0_x1(req0_x1), .req0_y1(req0_y1),
        .req0_color(req0_color),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x0(req1_x0), .req1_y0(req1_y0), .req1_x1(req1_x1), .req1_y1(req1_y1),
        .req1_color(req1_color),
        .drv(drv), .busy(busy), .grant_id(grant_id), .done_stb(done_stb),
        .err_stb(err_stb), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int busy_mode  = 0;

    // Driver-side stimulus: pix_ready 0=always, 1=toggle, 2=random; drv_busy random when busy_mode=1
    initial begin
        drv.pix_ready = 1'b1;
        drv.drv_busy  = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       drv.pix_ready = ~drv.pix_ready;
                2:       drv.pix_ready = ($urandom_range(0, 1) == 1);
                default: drv.pix_ready = 1'b1;
            endcase
            drv.drv_busy = (busy_mode != 0) && ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor / scoreboard counters
    int win_cnt = 0, start_cnt = 0, beat_cnt = 0, done_cnt = 0, err_cnt = 0;
    int color_bad = 0, busy_viol = 0;
    logic [15:0] exp_color = '0;
    logic [63:0] win_got = '0;
    logic prev_drv_busy = 1'b0;
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];

    always @(negedge clk) begin
        if (drv.win_set_stb) begin
            win_cnt++;
            win_got = {drv.win_x0, drv.win_y0, drv.win_x1, drv.win_y1};
            if (prev_drv_busy) busy_viol++;
        end
        if (drv.stream_start) begin
            start_cnt++;
            if (prev_drv_busy) busy_viol++;
        end
        if (drv.pix_valid) begin
            if (drv.pix_data !== exp_color) color_bad++;
            if (drv.pix_ready) beat_cnt++;
        end
        if (done_stb) done_cnt++;
        if (err_stb) err_cnt++;
        if (req0_valid && req0_ready) got_q.push_back(1'b0);
        if (req1_valid && req1_ready) got_q.push_back(1'b1);
        prev_drv_busy = drv.drv_busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    function automatic logic [88:0] all_outs();
        return {busy, grant_id, done_stb, err_stb, req0_ready, req1_ready,
                drv.win_set_stb, drv.stream_start, drv.pix_valid, drv.pix_data,
                drv.win_x0, drv.win_y0, drv.win_x1, drv.win_y1};
    endfunction

    // Reference model: rejection rule, clipping and pixel count from plain arithmetic
    function automatic void model(input int x0, y0, x1, y1,
                                  output bit err, output int wx1, wy1, beats);
        err   = (x0 > x1) || (y0 > y1) || (x0 >= X_RES) || (y0 >= Y_RES);
        wx1   = (x1 < X_RES) ? x1 : X_RES - 1;
        wy1   = (y1 < Y_RES) ? y1 : Y_RES - 1;
        beats = err ? 0 : (wx1 - x0 + 1) * (wy1 - y0 + 1);
    endfunction

    task automatic send(input int id, input int x0, y0, x1, y1, input logic [15:0] color);
        bit got;
        int n;
        @(posedge clk); #1;
        if (id == 0) begin
            req0_valid = 1'b1; req0_x0 = 16'(x0); req0_y0 = 16'(y0);
            req0_x1 = 16'(x1); req0_y1 = 16'(y1); req0_color = color;
        end else begin
            req1_valid = 1'b1; req1_x0 = 16'(x0); req1_y0 = 16'(y0);
            req1_x1 = 16'(x1); req1_y1 = 16'(y1); req1_color = color;
        end
        got = 0;
        n = 0;
        while (!got && n < 3000) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) got = 1;
            n++;
        end
        check($sformatf("grant_wait_req%0d", id), 32'(got), 32'd1);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic run_rect(input int id, input int x0, y0, x1, y1, input logic [15:0] color,
                            input bit e_err, input int e_wx1, e_wy1, e_beats, input string tag);
        int w0, s0, b0, d0, e0, c0, n;
        w0 = win_cnt; s0 = start_cnt; b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt; c0 = color_bad;
        exp_color = color;
        send(id, x0, y0, x1, y1, color);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_complete"}, 32'(n < 20000), 32'd1);
        repeat (4) tick();
        check({tag, "_err"},    32'(err_cnt - e0),   32'(e_err));
        check({tag, "_win"},    32'(win_cnt - w0),   e_err ? 32'd0 : 32'd1);
        check({tag, "_start"},  32'(start_cnt - s0), e_err ? 32'd0 : 32'd1);
        check({tag, "_done"},   32'(done_cnt - d0),  e_err ? 32'd0 : 32'd1);
        check({tag, "_beats"},  32'(beat_cnt - b0),  32'(e_beats));
        check({tag, "_color"},  32'(color_bad - c0), 32'd0);
        check({tag, "_gid"},    32'(grant_id),       32'(id));
        if (!e_err) begin
            check({tag, "_win_lo"}, win_got[63:32], {16'(x0), 16'(y0)});
            check({tag, "_win_hi"}, win_got[31:0],  {16'(e_wx1), 16'(e_wy1)});
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          id;
        int          x0, y0, x1, y1;
        logic [15:0] color;
        bit          err;
        int          wx1, wy1, beats;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n, b0, d0;
        bit m_err;
        int m_wx1, m_wy1, m_beats, rx0, ry0, rx1, ry1;

        vecs[0] = '{0, 10,  20,  12,   21,   16'hF800, 1'b0, 12,  21,  6};
        vecs[1] = '{1, 200, 300, 400,  500,  16'h07E0, 1'b0, 239, 319, 800};
        vecs[2] = '{0, 5,   5,   4,    9,    16'hFFFF, 1'b1, 0,   0,   0};
        vecs[3] = '{1, 0,   0,   0,    0,    16'h001F, 1'b0, 0,   0,   1};
        vecs[4] = '{0, 0,   0,   5,    0,    16'h8410, 1'b0, 5,   0,   6};
        vecs[5] = '{1, 239, 319, 239,  319,  16'hAAAA, 1'b0, 239, 319, 1};
        vecs[6] = '{0, 240, 0,   250,  5,    16'h1111, 1'b1, 0,   0,   0};
        vecs[7] = '{0, 0,   320, 0,    330,  16'h2222, 1'b1, 0,   0,   0};
        vecs[8] = '{1, 3,   4,   3,    2,    16'h3333, 1'b1, 0,   0,   0};
        vecs[9] = '{0, 230, 310, 1000, 1000, 16'h4444, 1'b0, 239, 319, 100};

        rst_n = 1'b0; init_done = 1'b0;
        req0_valid = 1'b0; req0_x0 = '0; req0_y0 = '0; req0_x1 = '0; req0_y1 = '0; req0_color = '0;
        req1_valid = 1'b0; req1_x0 = '0; req1_y0 = '0; req1_x1 = '0; req1_y1 = '0; req1_color = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'(|all_outs()), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(S_IDLE));
        rst_n = 1'b1;

        // No grant while the driver is not initialised
        req0_valid = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (req0_ready) n++;
        end
        check("no_grant_uninit", 32'(n), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        init_done  = 1'b1;

        foreach (vecs[i])
            run_rect(vecs[i].id, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color,
                     vecs[i].err, vecs[i].wx1, vecs[i].wy1, vecs[i].beats, $sformatf("vec%0d", i));

        // 2x2 with pix_ready toggling every cycle
        ready_mode = 1;
        run_rect(0, 50, 60, 51, 61, 16'h1234, 1'b0, 51, 61, 4, "toggle_2x2");
        ready_mode = 0;

        // Round-robin: both requesters valid together, two rounds
        do_reset();
        got_q.delete();
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_color = 16'h0F0F;
        for (int r = 0; r < 2; r++) begin
            d0 = done_cnt;
            fork
                send(0, 1, 1, 2, 2, 16'h0F0F);
                send(1, 3, 3, 4, 4, 16'h0F0F);
            join
            n = 0;
            while (done_cnt < d0 + 2 && n < 2000) begin
                tick();
                n++;
            end
            check($sformatf("rr_round%0d_done", r), 32'(done_cnt - d0), 32'd2);
        end
        check("rr_grant_count", 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            if (i < got_q.size()) check($sformatf("rr_grant%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

        // Random rectangles against the reference model, with random back-pressure and driver busy
        ready_mode = 2;
        busy_mode  = 1;
        for (int i = 0; i < 24; i++) begin
            rx0 = $urandom_range(2, 250);
            ry0 = $urandom_range(2, 330);
            rx1 = rx0 + $urandom_range(0, 12) - $urandom_range(0, 2);
            ry1 = ry0 + $urandom_range(0, 12) - $urandom_range(0, 2);
            model(rx0, ry0, rx1, ry1, m_err, m_wx1, m_wy1, m_beats);
            run_rect($urandom_range(0, 1), rx0, ry0, rx1, ry1, 16'($urandom()), m_err,
                     m_wx1, m_wy1, m_beats, $sformatf("rnd%0d", i));
        end
        ready_mode = 0;
        busy_mode  = 0;
        repeat (2) tick();

        // init_done falling mid-stream aborts without done_stb
        b0 = beat_cnt; d0 = done_cnt;
        exp_color = 16'hABCD;
        send(1, 0, 0, 20, 20, 16'hABCD);
        n = 0;
        while (beat_cnt < b0 + 5 && n < 200) begin
            tick();
            n++;
        end
        check("abort_stream_seen", 32'(beat_cnt >= b0 + 5), 32'd1);
        check("abort_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1;
        init_done = 1'b0;
        @(posedge clk); #1;
        check("abort_pix_valid", 32'(drv.pix_valid), 32'd0);
        check("abort_state", 32'(state_dbg), 32'(S_IDLE));
        repeat (5) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        init_done = 1'b1;

        // Reset asserted after 3 beats of a full-screen fill
        b0 = beat_cnt;
        exp_color = 16'h5555;
        send(0, 0, 0, 239, 319, 16'h5555);
        n = 0;
        while (beat_cnt < b0 + 3 && n < 200) begin
            tick();
            n++;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("midrst_beats", 32'(beat_cnt - b0), 32'd3);
        check("midrst_outs", 32'(|all_outs()), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'(S_IDLE));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        run_rect(0, 10, 20, 12, 21, 16'hF800, 1'b0, 12, 21, 6, "post_reset");

        check("win_start_while_busy", 32'(busy_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
